// File: rtl/num2str.sv
// Binary integer to null-terminated ASCII decimal string, one character per clock.
// Digits are generated least significant first onto a small stack, then emitted most significant first.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | Ready high, waiting for Start
// INIT   | latch sign and magnitude every cycle until Start drops
// DIVIDE | push magnitude mod 10, divide by 10, until quotient is zero
// SIGN   | write '-' if negative, otherwise one empty cycle
// EMIT   | pop and write one ASCII digit per cycle
// TERM   | write the 0x00 terminator
module num2str #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5,
  parameter int ADDR_W = 8
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Start,
  input  logic [WIDTH-1:0]  Num,
  input  logic              Signed,
  output logic              Ready,
  output logic              WrStr,
  output logic [ADDR_W-1:0] StrAddr,
  output logic [7:0]        StrData
);

  localparam int CNT_W = $clog2(DIGITS + 1);
  localparam logic [WIDTH-1:0] TEN = WIDTH'(10);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_DIVIDE, S_SIGN, S_EMIT, S_TERM
  } state_t;

  state_t state, state_nxt;

  logic             neg;
  logic [WIDTH-1:0] mag;
  logic [CNT_W-1:0] count;
  logic [3:0]       stk [DIGITS];

  logic [WIDTH-1:0] quot;
  logic [3:0]       digit;
  logic [CNT_W-1:0] top_idx;
  logic             num_neg;

  assign quot    = mag / TEN;
  assign digit   = 4'(mag % TEN);
  assign top_idx = count - CNT_W'(1);
  assign num_neg = Signed & Num[WIDTH-1];

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (Start) state_nxt = S_INIT;
      S_INIT:   if (!Start) state_nxt = S_DIVIDE;
      S_DIVIDE: if (quot == '0) state_nxt = S_SIGN;
      S_SIGN:   state_nxt = S_EMIT;
      S_EMIT:   if (count == CNT_W'(1)) state_nxt = S_TERM;
      S_TERM:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    Ready   = 1'b0;
    WrStr   = 1'b0;
    StrData = 8'h00;
    case (state)
      S_IDLE: Ready = 1'b1;
      S_SIGN: if (neg) begin
        WrStr   = 1'b1;
        StrData = 8'h2D;
      end
      S_EMIT: begin
        WrStr   = 1'b1;
        StrData = 8'h30 + {4'h0, stk[top_idx]};
      end
      S_TERM: WrStr = 1'b1;
      default: ;
    endcase
  end

  // Two's-complement negate of the most negative value yields the correct unsigned magnitude.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      neg     <= 1'b0;
      mag     <= '0;
      count   <= '0;
      StrAddr <= '0;
      for (int i = 0; i < DIGITS; i++) stk[i] <= 4'h0;
    end else begin
      case (state)
        S_INIT: begin
          neg     <= num_neg;
          mag     <= num_neg ? -Num : Num;
          count   <= '0;
          StrAddr <= '0;
        end
        S_DIVIDE: begin
          stk[count] <= digit;
          mag        <= quot;
          count      <= count + CNT_W'(1);
        end
        S_SIGN: if (neg) StrAddr <= StrAddr + ADDR_W'(1);
        S_EMIT: begin
          count   <= count - CNT_W'(1);
          StrAddr <= StrAddr + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_num2str.sv
// Self-checking bench for num2str: directed, randomized, held-Start and mid-conversion reset scenarios.
// Expected strings come from a decimal formatting model, not from the RTL structure.
module tb_num2str;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic        Start = 1'b0;
  logic [15:0] Num = '0;
  logic        Signed = 1'b0;
  logic        Ready;
  logic        WrStr;
  logic [7:0]  StrAddr;
  logic [7:0]  StrData;

  int total = 0;
  int bad = 0;

  logic [15:0] wlog[$];
  logic [7:0]  expq[$];
  int          exp_dig;
  int          lat;
  bit          timed_out;

  num2str #(.WIDTH(16), .DIGITS(5), .ADDR_W(8)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Num(Num), .Signed(Signed),
    .Ready(Ready), .WrStr(WrStr), .StrAddr(StrAddr), .StrData(StrData)
  );

  always #5 Clk = ~Clk;

  // String memory observer: captures what the memory would latch on the following rising edge.
  always @(negedge Clk) if (Rst && WrStr) wlog.push_back({StrAddr, StrData});

  function automatic void make_exp(input logic [15:0] n, input logic s);
    string d;
    int v;
    expq.delete();
    if (s && n[15]) begin
      v = 65536 - int'(n);
      expq.push_back(8'h2D);
    end else begin
      v = int'(n);
    end
    d = $sformatf("%0d", v);
    for (int i = 0; i < d.len(); i++) expq.push_back(d[i]);
    expq.push_back(8'h00);
    exp_dig = d.len();
  endfunction

  // Drives one conversion; Start high for 'hold' cycles, optional one-cycle Start poke at latency 'poke'.
  task automatic convert(input logic [15:0] n, input logic s, input int hold, input int poke);
    wlog.delete();
    timed_out = 1'b0;
    @(negedge Clk);
    Num = n; Signed = s; Start = 1'b1;
    repeat (hold - 1) @(negedge Clk);
    @(negedge Clk);
    Start = 1'b0;
    @(posedge Clk);
    lat = 0;
    while (1) begin
      @(posedge Clk);
      lat++;
      @(negedge Clk);
      Start = (poke != 0 && lat == poke);
      if (Ready) break;
      if (lat > 200) begin
        timed_out = 1'b1;
        break;
      end
    end
    Start = 1'b0;
  endtask

  task automatic test_reset;
    Rst = 1'b0;
    #12;
    total++;
    if (Ready !== 1'b1 || WrStr !== 1'b0 || StrAddr !== 8'h00 || StrData !== 8'h00) begin
      bad++;
      $display("FAIL reset_state: got ready=%b wr=%b addr=%h data=%h, want 1 0 00 00", Ready, WrStr, StrAddr, StrData);
    end
    @(negedge Clk);
    Rst = 1'b1;
  endtask

  task automatic test_directed;
    logic [15:0] dn [6] = '{16'd123, 16'hFF85, 16'hFF85, 16'h0000, 16'h8000, 16'hFFFF};
    logic        ds [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int t = 0; t < 6; t++) begin
      make_exp(dn[t], ds[t]);
      convert(dn[t], ds[t], 1, 0);
      total++;
      if (timed_out) begin
        bad++;
        $display("FAIL directed_timeout: num=%h ready never returned", dn[t]);
      end
      total++;
      if (lat !== 2 * exp_dig + 2) begin
        bad++;
        $display("FAIL directed_latency: num=%h got %0d cycles, want %0d", dn[t], lat, 2 * exp_dig + 2);
      end
      total++;
      if (wlog.size() != expq.size()) begin
        bad++;
        $display("FAIL directed_count: num=%h got %0d writes, want %0d", dn[t], wlog.size(), expq.size());
      end
      for (int i = 0; i < expq.size() && i < wlog.size(); i++) begin
        total++;
        if (wlog[i] !== {8'(i), expq[i]}) begin
          bad++;
          $display("FAIL directed_char: num=%h idx=%0d got addr/data %h, want %h", dn[t], i, wlog[i], {8'(i), expq[i]});
        end
      end
    end
  endtask

  task automatic test_random;
    logic [15:0] n;
    logic        s;
    for (int t = 0; t < 25; t++) begin
      n = 16'($urandom);
      if (t % 4 == 0) n = n >> $urandom_range(4, 15);
      s = 1'($urandom_range(0, 1));
      make_exp(n, s);
      convert(n, s, $urandom_range(1, 3), 0);
      total++;
      if (timed_out || lat !== 2 * exp_dig + 2) begin
        bad++;
        $display("FAIL random_latency: num=%h s=%b got %0d cycles (timeout=%b), want %0d", n, s, lat, timed_out, 2 * exp_dig + 2);
      end
      total++;
      if (wlog.size() != expq.size()) begin
        bad++;
        $display("FAIL random_count: num=%h s=%b got %0d writes, want %0d", n, s, wlog.size(), expq.size());
      end
      for (int i = 0; i < expq.size() && i < wlog.size(); i++) begin
        total++;
        if (wlog[i] !== {8'(i), expq[i]}) begin
          bad++;
          $display("FAIL random_char: num=%h s=%b idx=%0d got %h, want %h", n, s, i, wlog[i], {8'(i), expq[i]});
        end
      end
    end
  endtask

  task automatic test_start_held;
    logic [15:0] held_exp [3] = '{16'h0034, 16'h0132, 16'h0200};
    wlog.delete();
    @(negedge Clk);
    Num = 16'd7; Signed = 1'b0; Start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      if (i == 2) Num = 16'd42;
      total++;
      if (Ready !== 1'b0 || WrStr !== 1'b0) begin
        bad++;
        $display("FAIL held_init: cycle %0d got ready=%b wr=%b, want 0 0", i, Ready, WrStr);
      end
    end
    Start = 1'b0;
    lat = 0;
    while (!Ready && lat < 100) begin
      @(negedge Clk);
      lat++;
    end
    total++;
    if (wlog.size() != 3) begin
      bad++;
      $display("FAIL held_count: got %0d writes, want 3", wlog.size());
    end
    for (int i = 0; i < 3 && i < wlog.size(); i++) begin
      total++;
      if (wlog[i] !== held_exp[i]) begin
        bad++;
        $display("FAIL held_char: idx=%0d got %h, want %h", i, wlog[i], held_exp[i]);
      end
    end
  endtask

  task automatic test_start_during_emit;
    make_exp(16'd12345, 1'b0);
    convert(16'd12345, 1'b0, 1, 7);
    total++;
    if (timed_out || lat !== 12) begin
      bad++;
      $display("FAIL poke_latency: got %0d cycles (timeout=%b), want 12", lat, timed_out);
    end
    total++;
    if (wlog.size() != expq.size()) begin
      bad++;
      $display("FAIL poke_count: got %0d writes, want %0d", wlog.size(), expq.size());
    end
    for (int i = 0; i < expq.size() && i < wlog.size(); i++) begin
      total++;
      if (wlog[i] !== {8'(i), expq[i]}) begin
        bad++;
        $display("FAIL poke_char: idx=%0d got %h, want %h", i, wlog[i], {8'(i), expq[i]});
      end
    end
    repeat (3) begin
      @(negedge Clk);
      total++;
      if (Ready !== 1'b1) begin
        bad++;
        $display("FAIL poke_idle: got ready=%b, want 1", Ready);
      end
    end
  endtask

  task automatic test_reset_mid_emit;
    wlog.delete();
    @(negedge Clk);
    Num = 16'd12345; Signed = 1'b1; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    @(posedge Clk);
    // Edges 1..5 divide, 6 sign, 7 and 8 emit the first two digits
    repeat (8) @(posedge Clk);
    @(negedge Clk);
    #2 Rst = 1'b0;
    #1;
    total++;
    if (WrStr !== 1'b0 || Ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_async: got wr=%b ready=%b, want 0 1", WrStr, Ready);
    end
    total++;
    if (wlog.size() < 2 || wlog[0] !== 16'h0031 || wlog[1] !== 16'h0132) begin
      bad++;
      $display("FAIL rst_partial: got %0d writes first=%h second=%h, want 0031 0132", wlog.size(),
               wlog.size() > 0 ? wlog[0] : 16'hxxxx, wlog.size() > 1 ? wlog[1] : 16'hxxxx);
    end
    @(negedge Clk);
    Rst = 1'b1;
    make_exp(16'hFFF6, 1'b1);
    convert(16'hFFF6, 1'b1, 2, 0);
    total++;
    if (timed_out || wlog.size() != expq.size()) begin
      bad++;
      $display("FAIL rst_reconvert_count: got %0d writes (timeout=%b), want %0d", wlog.size(), timed_out, expq.size());
    end
    for (int i = 0; i < expq.size() && i < wlog.size(); i++) begin
      total++;
      if (wlog[i] !== {8'(i), expq[i]}) begin
        bad++;
        $display("FAIL rst_reconvert_char: idx=%0d got %h, want %h", i, wlog[i], {8'(i), expq[i]});
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_start_held();
    test_start_during_emit();
    test_random();
    test_reset_mid_emit();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/num2str.md
Name: num2str

Overview:
- Converts a binary integer into a null-terminated ASCII decimal string. Characters are written one per cycle into the string memory.
- Sits directly downstream of the CPU datapath and is the output-side counterpart of the string-to-number converter. It produces strings in the same format that block consumes: optional leading '-', digits 0x30..0x39, then a 0x00 terminator.
- Controller and datapath live in one module. Handshake is Start/Ready.

Parameters:
- WIDTH, 16: width of the input number.
- DIGITS, 5: depth of the digit stack. Must be at least the decimal digit count of 2^WIDTH-1.
- ADDR_W, 8: width of the string-memory address.

Ports:
- Clk, input, 1: rising-edge clock.
- Rst, input, 1: asynchronous, active-low reset.
- Start, input, 1: level request. Conversion begins when Start falls after being sampled high in Idle.
- Num, input, WIDTH: number to convert. Sampled every cycle in Init.
- Signed, input, 1: 1 means Num is two's complement; 0 means unsigned. Sampled with Num.
- Ready, output, 1: high only in Idle.
- WrStr, output, 1: string-memory write strobe.
- StrAddr, output, ADDR_W: write address, relative offset starting at 0.
- StrData, output, 8: write data (ASCII).

Behaviour:

Reset (Rst low, async):
- State goes to Idle immediately.
- WrStr=0, StrAddr=0, StrData=0, digit count=0, Ready=1.
- Reset mid-conversion abandons the string. Partially written characters stay in memory with no terminator.

State machine (Moore outputs, state register clocked on Clk):
- Idle:
  - Ready=1. Start=1 -> Init, else stay.
- Init:
  - Each cycle, latch Neg = Signed & Num[WIDTH-1].
  - Latch Mag = Neg ? -Num : Num, as a WIDTH-bit unsigned value.
  - Clear the digit count and StrAddr.
  - Start=1 -> stay in Init; Start=0 -> Divide. The last sampled Num is used.
- Divide:
  - Push Mag%10 onto the digit stack, Mag <= Mag/10, count++.
  - If Mag/10==0, go to Sign after this push; otherwise stay.
  - At least one digit is always pushed, so 0 yields "0".
  - The divide by 10 is combinational, one digit per cycle.
- Sign:
  - If Neg: WrStr=1, StrData=0x2D, StrAddr increments on the clock edge.
  - If not Neg: no write, one idle cycle.
  - Always -> Emit.
- Emit:
  - WrStr=1, StrData = 0x30 + top of stack, then pop and count--, StrAddr++.
  - Digits come out most significant first.
  - If count reaches 0 after this pop -> Term.
- Term:
  - WrStr=1, StrData=0x00, at the current StrAddr.
  - -> Idle.

Datapath and rules:
- StrAddr and StrData present valid values whenever WrStr=1. Memory captures them on the same rising edge.
- Most negative input (0x8000, WIDTH=16, Signed=1) gives Mag=32768 with no overflow. Output is "-32768".
- Start and Num are ignored outside Idle and Init. Start held high in Idle or Init keeps the block in Init.
- Total cycles from Start falling to Ready = n (Divide) + 1 (Sign) + n (Emit) + 1 (Term), where n = digit count.
- Characters written = n + 1 + Neg.
- The stack never overflows when DIGITS meets its rule.
- StrAddr wraps modulo 2^ADDR_W. This is unreachable for the defaults.

Test Plan:
- Positive value: Num=123, Signed=1, Start pulsed high for 1 cycle.
  - Writes '1'(0x31)@0, '2'(0x32)@1, '3'(0x33)@2, 0x00@3.
  - Ready returns 8 cycles after Start falls: 3 Divide + Sign + 3 Emit + Term.
- Negative value: Num=0xFF85 (-123), Signed=1.
  - Writes 0x2D@0, 0x31@1, 0x32@2, 0x33@3, 0x00@4.
  - Same unsigned with Signed=0: "65413" @0..4, 0x00@5.
- Zero and extremes:
  - Num=0 -> 0x30@0, 0x00@1.
  - Num=0x8000, Signed=1 -> "-32768" @0..5, 0x00@6.
  - Num=0xFFFF, Signed=0 -> "65535" @0..4, 0x00@5.
- Start held high for 5 cycles while Num changes 7 -> 42.
  - Block stays in Init with Ready=0 and no writes.
  - Converts 42 after the fall: 0x34@0, 0x32@1, 0x00@2.
  - Start pulses during Emit are ignored.
- Rst pulled low during Emit of 12345 (after 2 digits).
  - Asynchronously: WrStr=0 and Ready=1 before the next Clk edge.
  - A new Start then converts cleanly from StrAddr 0.
